// File: rtl/fetch.sv
// Instruction-fetch stage feeding decode.
// Owns the architectural PC and issues one instruction-memory read per enable pulse.
// It then waits a fixed read latency and presents {pc_out, command} together with a
// one-cycle done pulse. A redirect (jump_en/jump_addr) only takes effect when it comes
// with an enable.
// The memory read data must be valid on the clock edge MEM_LATENCY cycles after the edge
// that registered imem_addr. The registered address counts as the first of those cycles.
module fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 15,
    parameter int          MEM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   jump_en,
    input  logic [31:0]            jump_addr,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            pc_out,
    output logic [31:0]            command,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            pc_reg_q, pc_reg_d;
    logic [31:0]            fa_q, fa_d;
    logic [CNT_W-1:0]       counter_q, counter_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [31:0]            pc_out_q, pc_out_d;
    logic [31:0]            command_q, command_d;
    logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]            fetch_addr;

    // Target of a new fetch: an aligned redirect address or the running PC.
    assign fetch_addr = jump_en ? {jump_addr[31:2], 2'b00} : pc_reg_q;

    // Next-state and datapath updates; every register holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        pc_reg_d    = pc_reg_q;
        fa_d        = fa_q;
        counter_d   = counter_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pc_out_d    = pc_out_q;
        command_d   = command_q;
        imem_addr_d = imem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    fa_d        = fetch_addr;
                    imem_addr_d = fetch_addr[IMEM_ADDR_W+1:2];
                    counter_d   = CNT_W'(MEM_LATENCY - 1);
                    busy_d      = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (counter_q == '0) begin
                    command_d = imem_rdata;
                    pc_out_d  = fa_q;
                    pc_reg_d  = fa_q + 32'd4;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    counter_d = counter_q - 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset; an abandoned fetch produces no done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_reg_q    <= RESET_PC;
            fa_q        <= RESET_PC;
            counter_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pc_out_q    <= 32'h0;
            command_q   <= 32'h0;
            imem_addr_q <= RESET_PC[IMEM_ADDR_W+1:2];
        end else begin
            state_q     <= state_d;
            pc_reg_q    <= pc_reg_d;
            fa_q        <= fa_d;
            counter_q   <= counter_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pc_out_q    <= pc_out_d;
            command_q   <= command_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pc_out    = pc_out_q;
    assign command   = command_q;
    assign imem_addr = imem_addr_q;

endmodule

// File: tb/tb_fetch.sv
// Directed testbench for the fetch stage.
// The instruction memory is a registered-read array: data for a word address is
// returned on the clock edge after the address was registered.
module tb_fetch;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        busy;
    logic        done;
    logic [31:0] pc_out;
    logic [31:0] command;
    logic [14:0] imem_addr;
    logic [31:0] imem_rdata;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_ADDR_W(15),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .busy      (busy),
        .done      (done),
        .pc_out    (pc_out),
        .command   (command),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read instruction memory.
    always @(posedge clk) imem_rdata <= mem[imem_addr[9:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse enable at a negedge, wait (bounded) for done, and check the result.
    task automatic do_fetch(input string tag, input logic je, input logic [31:0] ja,
                            input logic [31:0] exp_pc, input logic [31:0] exp_cmd,
                            input logic [31:0] exp_iaddr);
        int cyc;
        enable    = 1'b1;
        jump_en   = je;
        jump_addr = ja;
        cyc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cyc++;
            enable  = 1'b0;
            jump_en = 1'b0;
            if (done) break;
        end
        check({tag, " latency"}, cyc, LAT + 1);
        check({tag, " pc_out"}, pc_out, exp_pc);
        check({tag, " command"}, command, exp_cmd);
        check({tag, " imem_addr"}, {17'h0, imem_addr}, exp_iaddr);
        $display("fetch %s: pc_out=%h command=%h imem_addr=%h cycles=%0d",
                 tag, pc_out, command, imem_addr, cyc);
        @(negedge clk);
        check({tag, " done one cycle"}, {31'h0, done}, 32'h0);
        check({tag, " pc_out hold"}, pc_out, exp_pc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int last;
        int cyc;
        int dones;
        logic [31:0] exp_pc;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h2001_0005;

        enable    = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 32'h0;
        rst       = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset values
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset pc_out", pc_out, 32'h0);
        check("reset command", command, 32'h0);
        check("reset imem_addr", {17'h0, imem_addr}, 32'h0);

        // 1: first fetch from RESET_PC
        do_fetch("t1", 1'b0, 32'h0, 32'h0, 32'h2001_0005, 32'h0);

        // 2: three back-to-back fetches, each enable raised on the done cycle
        do_reset();
        enable = 1'b1;
        n = 0;
        last = 0;
        cyc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cyc++;
            enable = 1'b0;
            if (done) begin
                exp_pc = 32'(n * 4);
                check("t2 pc_out", pc_out, exp_pc);
                check("t2 command", command, mem[n]);
                if (n > 0) check("t2 spacing", cyc - last, LAT + 1);
                $display("fetch t2.%0d: pc_out=%h command=%h cycle=%0d", n, pc_out, command, cyc);
                last = cyc;
                n++;
                if (n < 3) enable = 1'b1;
            end
        end
        check("t2 done count", n, 3);

        // 3: redirect with misaligned target, then sequential fetch
        do_fetch("t3 jump", 1'b1, 32'h0000_0103, 32'h0000_0100, 32'hA000_0040, 32'h40);
        do_fetch("t3 next", 1'b0, 32'h0, 32'h0000_0104, 32'hA000_0041, 32'h41);

        // 4: enable with a redirect while busy is ignored
        enable = 1'b1;
        @(negedge clk);
        check("t4 busy", {31'h0, busy}, 32'h1);
        enable    = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 32'h0000_0200;
        @(negedge clk);
        enable  = 1'b0;
        jump_en = 1'b0;
        dones = 0;
        if (done) begin
            dones++;
            check("t4 pc_out", pc_out, 32'h0000_0108);
            check("t4 command", command, 32'hA000_0042);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t4 done count", dones, 1);
        check("t4 pc_out hold", pc_out, 32'h0000_0108);
        $display("fetch t4: pc_out=%h command=%h dones=%0d", pc_out, command, dones);

        // 5: PC wrap at the top of the address space
        do_fetch("t5 top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hA000_03FF, 32'h7FFF);
        do_fetch("t5 wrap", 1'b0, 32'h0, 32'h0, 32'h2001_0005, 32'h0);

        // jump_en without enable has no effect
        jump_en   = 1'b1;
        jump_addr = 32'h0000_0300;
        repeat (3) @(negedge clk);
        check("nojump done", {31'h0, done}, 32'h0);
        jump_en = 1'b0;
        do_fetch("nojump", 1'b0, 32'h0, 32'h0000_0004, 32'hA000_0001, 32'h1);

        // 6: reset one cycle into WAIT abandons the fetch
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check("t6 busy before rst", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("t6 busy", {31'h0, busy}, 32'h0);
        check("t6 pc_out", pc_out, 32'h0);
        check("t6 command", command, 32'h0);
        check("t6 imem_addr", {17'h0, imem_addr}, 32'h0);
        dones = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t6 no done", dones, 0);
        $display("reset t6: busy=%b pc_out=%h dones=%0d", busy, pc_out, dones);
        do_fetch("t6 after", 1'b0, 32'h0, 32'h0, 32'h2001_0005, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
